// File: rtl/ex_mdu.sv
// Iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide, one step per cycle, with a pipeline stall while busy.
module ex_mdu #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] rs1,
    input  logic [WIDTH-1:0] rs2,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             neg_q, neg_d;
    logic [DW-1:0]    acc_q, acc_d;
    logic [WIDTH-1:0] result_q, result_d;

    // Operand decode for the accept cycle
    logic             accept, signed_a, signed_b, rs1_neg, rs2_neg;
    logic             div_by_zero, div_ovf, special, last_step;
    logic [WIDTH-1:0] abs1, abs2, spec_res;

    // Per-cycle step datapath and final result formatting
    logic [WIDTH:0]   mul_sum;
    logic [DW-1:0]    mul_next, mul_prod;
    logic [WIDTH:0]   div_r, div_t;
    logic [DW-1:0]    div_next;
    logic [WIDTH-1:0] mul_res, div_sel, div_res;

    always_comb begin
        accept      = (state_q == S_IDLE) && start && !flush;
        signed_a    = (funct3 == 3'd1) || (funct3 == 3'd2) || (funct3 == 3'd4) || (funct3 == 3'd6);
        signed_b    = (funct3 == 3'd1) || (funct3 == 3'd4) || (funct3 == 3'd6);
        rs1_neg     = signed_a && rs1[WIDTH-1];
        rs2_neg     = signed_b && rs2[WIDTH-1];
        abs1        = rs1_neg ? (~rs1 + WIDTH'(1)) : rs1;
        abs2        = rs2_neg ? (~rs2 + WIDTH'(1)) : rs2;
        div_by_zero = (rs2 == '0);
        div_ovf     = ((funct3 == 3'd4) || (funct3 == 3'd6))
                      && (rs1 == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2 == '1);
        special     = funct3[2] && (div_by_zero || div_ovf);
        if (div_by_zero) begin
            spec_res = funct3[1] ? rs1 : '1;
        end else begin
            spec_res = funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
    end

    always_comb begin
        last_step = (cnt_q == CW'(WIDTH - 1));
        mul_sum   = {1'b0, acc_q[DW-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
        mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
        mul_prod  = neg_q ? (~mul_next + DW'(1)) : mul_next;
        mul_res   = (op_q[1:0] == 2'd0) ? mul_prod[WIDTH-1:0] : mul_prod[DW-1:WIDTH];

        // Restoring step: shift in the next dividend bit, subtract divisor if it fits
        div_r     = acc_q[DW-1:WIDTH-1];
        div_t     = div_r - {1'b0, b_q};
        div_next  = div_t[WIDTH] ? {div_r[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                 : {div_t[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
        div_sel   = op_q[1] ? div_next[DW-1:WIDTH] : div_next[WIDTH-1:0];
        div_res   = neg_q ? (~div_sel + WIDTH'(1)) : div_sel;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!funct3[2]) begin
                        state_d = S_MUL;
                    end else if (special) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (last_step) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy  = 1'b0;
        done  = 1'b0;
        stall = 1'b0;
        busy  = (state_q == S_MUL) || (state_q == S_DIV);
        done  = (state_q == S_DONE);
        stall = busy || (start && (state_q == S_IDLE) && !flush);
    end

    // Datapath next-value logic
    always_comb begin
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d  = funct3;
                    a_d   = abs1;
                    b_d   = abs2;
                    neg_d = (funct3 == 3'd6) ? rs1_neg : (rs1_neg ^ rs2_neg);
                    cnt_d = '0;
                    acc_d = funct3[2] ? {{WIDTH{1'b0}}, abs1} : {{WIDTH{1'b0}}, abs2};
                    if (special) begin
                        result_d = spec_res;
                    end
                end
            end
            S_MUL: begin
                if (!flush) begin
                    acc_d = mul_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        result_d = mul_res;
                    end
                end
            end
            S_DIV: begin
                if (!flush) begin
                    acc_d = div_next;
                    cnt_d = cnt_q + CW'(1);
                    if (last_step) begin
                        result_d = div_res;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_ex_mdu.sv
// Directed bench for ex_mdu: arithmetic results, latency, stall, flush, reset and ignored starts.
module tb_ex_mdu;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        flush;
    logic [2:0]  funct3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;
    logic        done;
    logic        stall;
    logic [31:0] result;

    int vecs = 0;
    int errs = 0;

    ex_mdu #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .rs1    (rs1),
        .rs2    (rs2),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .stall  (stall),
        .result (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation, scramble inputs after acceptance, and check latency/stall/result
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat);
        int cyc;
        int stl;
        start  = 1'b1;
        funct3 = f;
        rs1    = a;
        rs2    = b;
        #1;
        check({tag, " stall_at_start"}, 32'(stall), 32'd1);
        step();
        start  = 1'b0;
        funct3 = ~f;
        rs1    = ~a;
        rs2    = b + 32'd1;
        #1;
        cyc = 0;
        stl = 1;
        while (!done && cyc < 40) begin
            if (stall) stl++;
            step();
            cyc++;
        end
        check({tag, " latency"}, 32'(cyc), 32'(lat));
        check({tag, " stall_cycles"}, 32'(stl), 32'(lat + 1));
        check({tag, " result"}, result, exp);
        check({tag, " stall_in_done"}, 32'(stall), 32'd0);
        step();
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " result_held"}, result, exp);
    endtask

    initial begin
        int cyc;
        rst    = 1'b1;
        start  = 1'b0;
        flush  = 1'b0;
        funct3 = 3'd0;
        rs1    = '0;
        rs2    = '0;
        step();
        step();
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset result", result, 32'd0);
        check("reset stall", 32'(stall), 32'd0);
        rst = 1'b0;
        step();

        run_op("MUL 7*6",        3'd0, 32'd7,        32'd6,        32'd42,       32);
        repeat (3) step();
        check("MUL result held idle", result, 32'd42);
        run_op("MUL -1*2 low",   3'd0, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32);
        run_op("MULH min*min",   3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32);
        run_op("MULHSU -1*max",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32);
        run_op("MULHU max*max",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32);
        run_op("DIV -7/2",       3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32);
        run_op("REM -7/2",       3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32);
        run_op("DIVU 100/7",     3'd5, 32'd100,      32'd7,        32'd14,       32);
        run_op("REMU 100/7",     3'd7, 32'd100,      32'd7,        32'd2,        32);
        run_op("DIVU 5/0",       3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 0);
        run_op("REM 5/0",        3'd6, 32'd5,        32'd0,        32'd5,        0);
        run_op("DIV ovf",        3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0);
        run_op("REM ovf",        3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        0);
        run_op("DIVU min/-1",    3'd5, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32);
        run_op("DIV 7/-2",       3'd4, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32);
        run_op("REM 7/-2",       3'd6, 32'd7,        32'hFFFFFFFE, 32'd1,        32);

        // Flush a divide mid-flight
        start  = 1'b1;
        funct3 = 3'd5;
        rs1    = 32'd100;
        rs2    = 32'd7;
        step();
        start = 1'b0;
        repeat (10) step();
        check("flush pre busy", 32'(busy), 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("flush busy", 32'(busy), 32'd0);
        check("flush done", 32'(done), 32'd0);
        check("flush result kept", result, 32'd1);
        for (int i = 0; i < 30; i++) begin
            check("flush no late done", 32'(done), 32'd0);
            step();
        end

        // Flush in IDLE suppresses start
        start  = 1'b1;
        flush  = 1'b1;
        funct3 = 3'd0;
        rs1    = 32'd4;
        rs2    = 32'd4;
        #1;
        check("idle flush stall", 32'(stall), 32'd0);
        step();
        start = 1'b0;
        flush = 1'b0;
        check("idle flush busy", 32'(busy), 32'd0);
        check("idle flush result", result, 32'd1);

        run_op("MUL 3*3 after flush", 3'd0, 32'd3, 32'd3, 32'd9, 32);

        // Start during busy is ignored
        start  = 1'b1;
        funct3 = 3'd0;
        rs1    = 32'd5;
        rs2    = 32'd5;
        step();
        start = 1'b0;
        repeat (5) step();
        start  = 1'b1;
        funct3 = 3'd5;
        rs1    = 32'd99;
        rs2    = 32'd3;
        #1;
        check("busy start stall", 32'(stall), 32'd1);
        step();
        start = 1'b0;
        cyc = 6;
        while (!done && cyc < 40) begin
            step();
            cyc++;
        end
        check("ignored start latency", 32'(cyc), 32'd32);
        check("ignored start result", result, 32'd25);
        step();
        check("ignored start no relaunch", 32'(busy), 32'd0);

        // Reset mid-multiply
        start  = 1'b1;
        funct3 = 3'd0;
        rs1    = 32'd5;
        rs2    = 32'd6;
        step();
        start = 1'b0;
        repeat (20) step();
        check("pre reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid reset busy", 32'(busy), 32'd0);
        check("mid reset done", 32'(done), 32'd0);
        check("mid reset result", result, 32'd0);
        for (int i = 0; i < 15; i++) begin
            step();
            check("post reset no done", 32'(done), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
